// File: rtl/cluster_bus_isolate_ctrl.sv
// Tracks per-port outstanding AXI reads/writes, caps them, and drains/isolates the cluster bus on request.
// Optional drain watchdog: define CLUSTER_BUS_ISOLATE_TIMEOUT_EN.
module cluster_bus_isolate_ctrl #(
    parameter int unsigned NB_PORTS        = 4,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned DRAIN_TIMEOUT   = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                isolate_req_i,
    output logic                isolated_o,
    input  logic [NB_PORTS-1:0] slv_aw_valid_i,
    output logic [NB_PORTS-1:0] slv_aw_ready_o,
    output logic [NB_PORTS-1:0] xbar_aw_valid_o,
    input  logic [NB_PORTS-1:0] xbar_aw_ready_i,
    input  logic [NB_PORTS-1:0] slv_ar_valid_i,
    output logic [NB_PORTS-1:0] slv_ar_ready_o,
    output logic [NB_PORTS-1:0] xbar_ar_valid_o,
    input  logic [NB_PORTS-1:0] xbar_ar_ready_i,
    input  logic [NB_PORTS-1:0] b_valid_i,
    input  logic [NB_PORTS-1:0] b_ready_i,
    input  logic [NB_PORTS-1:0] r_valid_i,
    input  logic [NB_PORTS-1:0] r_ready_i,
    input  logic [NB_PORTS-1:0] r_last_i,
    output logic                err_o,
    output logic                timeout_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ISOLATED
    } state_e;

    if (MAX_OUTSTANDING < 1 || DRAIN_TIMEOUT < 1) begin : g_param_check
        $error("MAX_OUTSTANDING and DRAIN_TIMEOUT must be at least 1");
    end

    state_e              state_q, state_d;
    logic                blocked, isolated;
    logic                all_idle;
    cnt_t                wr_cnt_q [NB_PORTS];
    cnt_t                wr_cnt_d [NB_PORTS];
    cnt_t                rd_cnt_q [NB_PORTS];
    cnt_t                rd_cnt_d [NB_PORTS];
    logic [NB_PORTS-1:0] aw_pend_q, aw_pend_d, ar_pend_q, ar_pend_d;
    logic [NB_PORTS-1:0] gate_aw, gate_ar;
    logic [NB_PORTS-1:0] aw_hs, ar_hs, b_hs, r_hs, r_last_hs;
    logic [NB_PORTS-1:0] wr_uflow, rd_uflow;
    logic                err_q, err_d;

    // A pending valid keeps its path open so an address already shown to the crossbar is never withdrawn.
    always_comb begin
        for (int i = 0; i < NB_PORTS; i++) begin
            gate_aw[i] = (blocked | (wr_cnt_q[i] == CntMax)) & ~aw_pend_q[i];
            gate_ar[i] = (blocked | (rd_cnt_q[i] == CntMax)) & ~ar_pend_q[i];
        end
    end

    assign xbar_aw_valid_o = slv_aw_valid_i & ~gate_aw;
    assign slv_aw_ready_o  = xbar_aw_ready_i & ~gate_aw;
    assign xbar_ar_valid_o = slv_ar_valid_i & ~gate_ar;
    assign slv_ar_ready_o  = xbar_ar_ready_i & ~gate_ar;

    assign aw_hs     = xbar_aw_valid_o & xbar_aw_ready_i;
    assign ar_hs     = xbar_ar_valid_o & xbar_ar_ready_i;
    assign b_hs      = b_valid_i & b_ready_i;
    assign r_hs      = r_valid_i & r_ready_i;
    assign r_last_hs = r_hs & r_last_i;

    assign aw_pend_d = (xbar_aw_valid_o & ~xbar_aw_ready_i) | (~xbar_aw_valid_o & aw_pend_q);
    assign ar_pend_d = (xbar_ar_valid_o & ~xbar_ar_ready_i) | (~xbar_ar_valid_o & ar_pend_q);

    // NOTE: every output of a combinational block gets a default up front so no latch is inferred.
    always_comb begin
        wr_uflow = '0;
        rd_uflow = '0;
        for (int i = 0; i < NB_PORTS; i++) begin
            wr_cnt_d[i] = wr_cnt_q[i];
            rd_cnt_d[i] = rd_cnt_q[i];
            if (aw_hs[i] && !b_hs[i] && wr_cnt_q[i] != CntMax) begin
                wr_cnt_d[i] = wr_cnt_q[i] + 1'b1;
            end else if (b_hs[i] && !aw_hs[i]) begin
                if (wr_cnt_q[i] == '0) wr_uflow[i] = 1'b1;
                else                   wr_cnt_d[i] = wr_cnt_q[i] - 1'b1;
            end
            if (ar_hs[i] && !r_last_hs[i] && rd_cnt_q[i] != CntMax) begin
                rd_cnt_d[i] = rd_cnt_q[i] + 1'b1;
            end else if (r_last_hs[i] && !ar_hs[i]) begin
                if (rd_cnt_q[i] == '0) rd_uflow[i] = 1'b1;
                else                   rd_cnt_d[i] = rd_cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        all_idle = ~|{aw_pend_q, ar_pend_q};
        for (int i = 0; i < NB_PORTS; i++) begin
            if (wr_cnt_q[i] != '0 || rd_cnt_q[i] != '0) all_idle = 1'b0;
        end
    end

    // Any response seen while isolated has no matching request: flag it as a protocol error.
    assign err_d = err_q | (|wr_uflow) | (|rd_uflow) | (isolated & ((|b_hs) | (|r_hs)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping the request out of DRAIN wins over completing the drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:      if (isolate_req_i) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!isolate_req_i) state_d = ST_RUN;
                else if (all_idle)  state_d = ST_ISOLATED;
            end
            ST_ISOLATED: if (!isolate_req_i) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_comb begin
        blocked  = (state_q != ST_RUN);
        isolated = (state_q == ST_ISOLATED);
    end

    assign isolated_o = isolated;

    // NOTE: the counter arrays are control state, not storage, so they take the async reset like any flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_PORTS; i++) begin
                wr_cnt_q[i] <= '0;
                rd_cnt_q[i] <= '0;
            end
            aw_pend_q <= '0;
            ar_pend_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NB_PORTS; i++) begin
                wr_cnt_q[i] <= wr_cnt_d[i];
                rd_cnt_q[i] <= rd_cnt_d[i];
            end
            aw_pend_q <= aw_pend_d;
            ar_pend_q <= ar_pend_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef CLUSTER_BUS_ISOLATE_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(DRAIN_TIMEOUT + 1);
    typedef logic [TmrW-1:0] tmr_t;
    localparam tmr_t TmrMax = tmr_t'(DRAIN_TIMEOUT);

    tmr_t tmr_q, tmr_d;
    logic timeout_q, timeout_d;

    // Watchdog only flags a stuck drain; the FSM keeps waiting in DRAIN.
    always_comb begin
        tmr_d     = '0;
        timeout_d = timeout_q;
        if (state_q == ST_DRAIN) begin
            tmr_d = (tmr_q == TmrMax) ? tmr_q : tmr_q + 1'b1;
            if (tmr_d == TmrMax) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_bus_isolate_ctrl.sv
// Directed bench for cluster_bus_isolate_ctrl: vector table for pass-through/counting,
// hand sequences for drain, pending valid, cap, underflow, timeout and reset mid-drain.
module tb_cluster_bus_isolate_ctrl;

    localparam int unsigned NP = 4;
`ifdef CLUSTER_BUS_ISOLATE_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          isolate_req_i;
    logic          isolated_o;
    logic [NP-1:0] slv_aw_valid_i, slv_aw_ready_o, xbar_aw_valid_o, xbar_aw_ready_i;
    logic [NP-1:0] slv_ar_valid_i, slv_ar_ready_o, xbar_ar_valid_o, xbar_ar_ready_i;
    logic [NP-1:0] b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
    logic          err_o, timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    cluster_bus_isolate_ctrl #(
        .NB_PORTS       (NP),
        .MAX_OUTSTANDING(16),
        .DRAIN_TIMEOUT  (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .isolate_req_i  (isolate_req_i),
        .isolated_o     (isolated_o),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .xbar_aw_valid_o(xbar_aw_valid_o),
        .xbar_aw_ready_i(xbar_aw_ready_i),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .xbar_ar_valid_o(xbar_ar_valid_o),
        .xbar_ar_ready_i(xbar_ar_ready_i),
        .b_valid_i      (b_valid_i),
        .b_ready_i      (b_ready_i),
        .r_valid_i      (r_valid_i),
        .r_ready_i      (r_ready_i),
        .r_last_i       (r_last_i),
        .err_o          (err_o),
        .timeout_o      (timeout_o)
    );

    typedef struct {
        logic          req;
        logic [NP-1:0] aw_v, aw_r, ar_v, ar_r, b_v, b_r, r_v, r_r, r_l;
        logic          e_iso;
        logic [NP-1:0] e_awr, e_xaw, e_arr, e_xar;
        logic          e_err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        isolate_req_i   = 1'b0;
        slv_aw_valid_i  = '0;
        xbar_aw_ready_i = '0;
        slv_ar_valid_i  = '0;
        xbar_ar_ready_i = '0;
        b_valid_i       = '0;
        b_ready_i       = '0;
        r_valid_i       = '0;
        r_ready_i       = '0;
        r_last_i        = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic iso, input logic [NP-1:0] awr,
                              input logic [NP-1:0] xaw, input logic [NP-1:0] arr,
                              input logic [NP-1:0] xar, input logic err);
        check({tag, "_iso"},  isolated_o,      iso);
        check({tag, "_awr"},  slv_aw_ready_o,  awr);
        check({tag, "_xaw"},  xbar_aw_valid_o, xaw);
        check({tag, "_arr"},  slv_ar_ready_o,  arr);
        check({tag, "_xar"},  xbar_ar_valid_o, xar);
        check({tag, "_err"},  err_o,           err);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, aw_v, aw_r, ar_v, ar_r, b_v, b_r, r_v, r_r, r_l | iso, awr, xaw, arr, xar, err
        vecs[0] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0};
        vecs[1] = '{1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0};
        vecs[2] = '{1'b0, 4'h0, 4'hF, 4'hA, 4'hA, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'hA, 4'hA, 1'b0};
        vecs[3] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hA, 4'hA, 4'h2, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0};
        vecs[4] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0};
        vecs[5] = '{1'b0, 4'h3, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'hC, 4'h3, 4'h0, 4'h0, 1'b0};
        vecs[6] = '{1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0};
        vecs[7] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};

        // Reset state
        rst_ni = 1'b1;
        clr();
        #1 rst_ni = 1'b0;
        xbar_aw_ready_i = 4'hF;
        settle();
        check("rst_iso", isolated_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);
        check("rst_awr_pass", slv_aw_ready_o, 4'hF);
        #9 rst_ni = 1'b1;
        tick();

        // Table: pass-through and counting in RUN
        for (int k = 0; k < 8; k++) begin
            clr();
            isolate_req_i   = vecs[k].req;
            slv_aw_valid_i  = vecs[k].aw_v;
            xbar_aw_ready_i = vecs[k].aw_r;
            slv_ar_valid_i  = vecs[k].ar_v;
            xbar_ar_ready_i = vecs[k].ar_r;
            b_valid_i       = vecs[k].b_v;
            b_ready_i       = vecs[k].b_r;
            r_valid_i       = vecs[k].r_v;
            r_ready_i       = vecs[k].r_r;
            r_last_i        = vecs[k].r_l;
            settle();
            expect_all($sformatf("vec%0d", k), vecs[k].e_iso, vecs[k].e_awr, vecs[k].e_xaw,
                       vecs[k].e_arr, vecs[k].e_xar, vecs[k].e_err);
            tick();
        end

        // Idle bus isolation: isolated two cycles after request, resume one cycle after drop
        clr(); isolate_req_i = 1'b1; xbar_aw_ready_i = 4'hF; xbar_ar_ready_i = 4'hF;
        settle();
        check("idle_c0_iso", isolated_o, 1'b0);
        check("idle_c0_awr", slv_aw_ready_o, 4'hF);
        tick();
        for (int c = 1; c <= 2; c++) begin
            clr(); isolate_req_i = 1'b1; xbar_aw_ready_i = 4'hF; slv_aw_valid_i = 4'hF; xbar_ar_ready_i = 4'hF;
            settle();
            check($sformatf("idle_c%0d_iso", c), isolated_o, (c == 2));
            check($sformatf("idle_c%0d_awr", c), slv_aw_ready_o, 4'h0);
            check($sformatf("idle_c%0d_xaw", c), xbar_aw_valid_o, 4'h0);
            check($sformatf("idle_c%0d_arr", c), slv_ar_ready_o, 4'h0);
            tick();
        end
        clr(); xbar_aw_ready_i = 4'hF; slv_aw_valid_i = 4'hF;
        settle();
        check("idle_drop_iso_held", isolated_o, 1'b1);
        check("idle_drop_xaw", xbar_aw_valid_o, 4'h0);
        tick();
        clr(); xbar_aw_ready_i = 4'hF;
        settle();
        check("idle_resume_iso", isolated_o, 1'b0);
        check("idle_resume_awr", slv_aw_ready_o, 4'hF);
        tick();

        // Port 2: three outstanding reads must drain before isolation
        for (int c = 0; c < 3; c++) begin
            clr(); slv_ar_valid_i = 4'h4; xbar_ar_ready_i = 4'h4;
            settle();
            check($sformatf("rd3_issue%0d_xar", c), xbar_ar_valid_o, 4'h4);
            tick();
        end
        clr(); isolate_req_i = 1'b1;
        settle();
        check("rd3_req_iso", isolated_o, 1'b0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            clr(); isolate_req_i = 1'b1;
            if (c <= 4) begin
                r_valid_i = 4'h4; r_ready_i = 4'h4;
                r_last_i  = (c == 2) ? 4'h0 : 4'h4;
            end
            if (c == 1) begin
                slv_ar_valid_i = 4'h4; xbar_ar_ready_i = 4'hF;
            end
            settle();
            check($sformatf("rd3_d%0d_iso", c), isolated_o, 1'b0);
            if (c == 1) begin
                check("rd3_d1_xar_gated", xbar_ar_valid_o, 4'h0);
                check("rd3_d1_arr_gated", slv_ar_ready_o, 4'h0);
            end
            tick();
        end
        clr(); isolate_req_i = 1'b1;
        settle();
        check("rd3_done_iso", isolated_o, 1'b1);
        check("rd3_done_err", err_o, 1'b0);
        tick();
        clr(); settle(); tick();

        // Port 0 AW pending when isolation starts: valid is held until the handshake
        clr(); isolate_req_i = 1'b1; slv_aw_valid_i = 4'h1;
        settle();
        check("pend_p0_xaw", xbar_aw_valid_o, 4'h1);
        tick();
        clr(); isolate_req_i = 1'b1; slv_aw_valid_i = 4'h3;
        settle();
        expect_all("pend_p1", 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        clr(); isolate_req_i = 1'b1; slv_aw_valid_i = 4'h3; xbar_aw_ready_i = 4'h1;
        settle();
        check("pend_p2_xaw", xbar_aw_valid_o, 4'h1);
        check("pend_p2_awr", slv_aw_ready_o, 4'h1);
        tick();
        clr(); isolate_req_i = 1'b1; slv_aw_valid_i = 4'h2; xbar_aw_ready_i = 4'hF;
        settle();
        check("pend_p3_xaw", xbar_aw_valid_o, 4'h0);
        check("pend_p3_awr", slv_aw_ready_o, 4'h0);
        check("pend_p3_iso", isolated_o, 1'b0);
        tick();
        clr(); isolate_req_i = 1'b1; b_valid_i = 4'h1; b_ready_i = 4'h1;
        settle();
        check("pend_p4_iso", isolated_o, 1'b0);
        tick();
        clr(); isolate_req_i = 1'b1;
        settle();
        check("pend_p5_iso", isolated_o, 1'b0);
        tick();
        clr();
        settle();
        check("pend_p6_iso", isolated_o, 1'b1);
        tick();
        clr(); settle();
        check("pend_p7_iso", isolated_o, 1'b0);
        tick();

        // Port 1 cap at 16 outstanding writes
        for (int c = 0; c < 16; c++) begin
            clr(); slv_aw_valid_i = 4'h2; xbar_aw_ready_i = 4'hF;
            settle();
            check($sformatf("cap_aw%0d_xaw", c), xbar_aw_valid_o, 4'h2);
            tick();
        end
        clr(); slv_aw_valid_i = 4'h2; xbar_aw_ready_i = 4'hF;
        settle();
        check("cap_17th_xaw", xbar_aw_valid_o, 4'h0);
        check("cap_17th_awr", slv_aw_ready_o, 4'hD);
        tick();
        clr(); slv_aw_valid_i = 4'h2; xbar_aw_ready_i = 4'hF; b_valid_i = 4'h2; b_ready_i = 4'h2;
        settle();
        check("cap_b_same_cycle_xaw", xbar_aw_valid_o, 4'h0);
        tick();
        clr(); slv_aw_valid_i = 4'h2; xbar_aw_ready_i = 4'hF;
        settle();
        check("cap_after_b_xaw", xbar_aw_valid_o, 4'h2);
        check("cap_after_b_awr", slv_aw_ready_o, 4'hF);
        tick();
        clr(); slv_aw_valid_i = 4'h2; xbar_aw_ready_i = 4'hF;
        settle();
        check("cap_refull_xaw", xbar_aw_valid_o, 4'h0);
        tick();
        for (int c = 0; c < 16; c++) begin
            clr(); b_valid_i = 4'h2; b_ready_i = 4'h2;
            tick();
        end
        clr(); settle();
        check("cap_drained_err", err_o, 1'b0);
        tick();

        // Underflow on port 3: sticky error, counter held at 0 (proved by a fast isolation)
        clr(); b_valid_i = 4'h8; b_ready_i = 4'h8;
        settle();
        check("uflow_pre_err", err_o, 1'b0);
        tick();
        clr(); settle();
        check("uflow_err", err_o, 1'b1);
        tick();
        clr(); isolate_req_i = 1'b1; settle();
        check("uflow_sticky_err", err_o, 1'b1);
        tick();
        clr(); isolate_req_i = 1'b1; settle();
        check("uflow_drain_iso", isolated_o, 1'b0);
        tick();
        clr(); isolate_req_i = 1'b1; settle();
        check("uflow_cnt_zero_iso", isolated_o, 1'b1);
        tick();
        clr(); settle(); tick();
        clr(); settle();
        check("uflow_resume_iso", isolated_o, 1'b0);
        check("uflow_final_err", err_o, 1'b1);
        tick();

        // Read on port 0 never completes: stuck in DRAIN, watchdog when enabled
        clr(); slv_ar_valid_i = 4'h1; xbar_ar_ready_i = 4'h1;
        settle();
        check("tmo_issue_xar", xbar_ar_valid_o, 4'h1);
        tick();
        clr(); isolate_req_i = 1'b1; tick();
        for (int k = 1; k <= 10; k++) begin
            clr(); isolate_req_i = 1'b1; xbar_ar_ready_i = 4'hF;
            settle();
            check($sformatf("tmo_k%0d_iso", k), isolated_o, 1'b0);
            check($sformatf("tmo_k%0d_timeout", k), timeout_o, TimeoutEn && (k >= 9));
            check($sformatf("tmo_k%0d_arr", k), slv_ar_ready_o, 4'h0);
            tick();
        end

        // Asynchronous reset mid-drain returns to RUN and clears counters and flags
        clr(); isolate_req_i = 1'b1; xbar_aw_ready_i = 4'hF;
        rst_ni = 1'b0;
        settle();
        check("rstmid_iso", isolated_o, 1'b0);
        check("rstmid_err", err_o, 1'b0);
        check("rstmid_timeout", timeout_o, 1'b0);
        check("rstmid_awr", slv_aw_ready_o, 4'hF);
        #2 rst_ni = 1'b1;
        isolate_req_i = 1'b0;
        tick();
        clr(); isolate_req_i = 1'b1; tick();
        clr(); isolate_req_i = 1'b1; settle();
        check("rstmid_drain_iso", isolated_o, 1'b0);
        tick();
        clr(); isolate_req_i = 1'b1; settle();
        check("rstmid_cnt_cleared_iso", isolated_o, 1'b1);
        tick();
        clr(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
